// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - MM:SS BCD stopwatch with 1 Hz prescaler and start/pause/clear control.
// Optional lap display latch enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic [3:0] BCD3,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic       running,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [15:0]   cnt, cnt_next;
  logic          tick_next;

  // Packed as {min_tens, min_units, sec_tens, sec_units}; wraps 59:59 -> 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] s1, s10, m1, m10;
    {m10, m1, s10, s1} = t;
    if (s1 != 4'd9) begin
      s1 = s1 + 4'd1;
    end else begin
      s1 = 4'd0;
      if (s10 != 4'd5) begin
        s10 = s10 + 4'd1;
      end else begin
        s10 = 4'd0;
        if (m1 != 4'd9) begin
          m1 = m1 + 4'd1;
        end else begin
          m1  = 4'd0;
          m10 = (m10 != 4'd5) ? m10 + 4'd1 : 4'd0;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  always_comb begin
    state_next = state;
    presc_next = presc;
    cnt_next   = cnt;
    tick_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      presc_next = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_stop) state_next = RUN;
        end
        RUN: begin
          // A pause request on the terminal prescaler cycle still lets this tick land.
          if (presc == PRESC_LAST) begin
            presc_next = '0;
            tick_next  = 1'b1;
            cnt_next   = bcd_inc(cnt);
          end else begin
            presc_next = presc + 1'b1;
          end
          if (start_stop) state_next = PAUSE;
        end
        PAUSE: begin
          if (start_stop) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      cnt     <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      cnt     <= cnt_next;
      running <= (state_next == RUN);
      tick    <= tick_next;
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic [15:0] disp;
  logic        frozen;
  logic        frozen_next;

  assign frozen_next = frozen ^ (lap && (state == RUN));

  // The latch loads the value the live count takes on this edge unless it stays frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp   <= '0;
      frozen <= 1'b0;
    end else if (clear) begin
      disp   <= '0;
      frozen <= 1'b0;
    end else begin
      frozen <= frozen_next;
      if (!(frozen && frozen_next)) disp <= cnt_next;
    end
  end

  assign {BCD3, BCD2, BCD1, BCD0} = disp;
`else
  assign {BCD3, BCD2, BCD1, BCD0} = cnt;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - self-checking bench for bcd_stopwatch with TICK_DIV=4.
module tb_bcd_stopwatch;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic       running, tick;

  bcd_stopwatch #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
`ifdef BCD_STOPWATCH_LAP_EN
    .lap(lap),
`endif
    .BCD3(bcd3), .BCD2(bcd2), .BCD1(bcd1), .BCD0(bcd0),
    .running(running), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        run;
    logic        tk;
  } exp_t;

  typedef struct {
    logic        ss;
    logic        clr;
    int          cycles;
    logic [15:0] bcd;
    logic        run;
    logic        tk;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   checks = 0;
  int   failures = 0;

  // Reference model: integer seconds, not BCD digits.
  int m_state = 0;  // 0 idle, 1 run, 2 pause
  int m_presc = 0;
  int m_secs = 0;
  int m_disp = 0;
  bit m_frozen = 0;
  bit m_tick = 0;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [17:0] actual();
    return {bcd3, bcd2, bcd1, bcd0, running, tick};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_secs = 0; m_disp = 0; m_frozen = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic ss, input logic clr, input logic lp);
    int prev = m_state;
    m_tick = 0;
    if (clr) begin
      m_state = 0; m_presc = 0; m_secs = 0; m_frozen = 0;
    end else begin
      if (m_state == 1) begin
        if (m_presc == TD - 1) begin
          m_presc = 0; m_tick = 1; m_secs = (m_secs + 1) % 3600;
        end else begin
          m_presc++;
        end
        if (ss) m_state = 2;
      end else if (ss) begin
        m_state = 1;
      end
`ifdef BCD_STOPWATCH_LAP_EN
      if (lp && prev == 1) m_frozen = !m_frozen;
`endif
    end
    if (!m_frozen) m_disp = m_secs;
    sb.push_back('{to_bcd(m_disp), (m_state == 1), m_tick});
  endtask

  task automatic step(input logic ss, input logic clr, input logic lp);
    exp_t e;
    @(negedge clk);
    start_stop = ss; clear = clr; lap = lp;
    model_step(ss, clr, lp);
    @(posedge clk);
    #1;
    start_stop = 0; clear = 0; lap = 0;
    e = sb.pop_front();
    check("cycle", actual(), {e.bcd, e.run, e.tk});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 20,    16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 41,    16'h0010, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 2356,  16'h0959, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 4,     16'h1000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 11996, 16'h5959, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4,     16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 11,    16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1,     16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1,     16'h0001, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 24,    16'h0007, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1,     16'h0000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 20,    16'h0000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 4,     16'h0000, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1,     16'h0001, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 5,     16'h0001, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1,     16'h0000, 1'b0, 1'b0};

    #1 rst = 1'b1;
    #1 check("reset_async", actual(), 18'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].ss, vecs[i].clr, 1'b0);
      for (int c = 1; c < vecs[i].cycles; c++) step(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d", i), actual(), {vecs[i].bcd, vecs[i].run, vecs[i].tk});
    end

`ifdef BCD_STOPWATCH_LAP_EN
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 19; c++) step(1'b0, 1'b0, 1'b0);
    check("lap_frozen", actual(), {16'h0003, 1'b1, 1'b1});
    step(1'b0, 1'b0, 1'b1);
    check("lap_release", actual(), {16'h0008, 1'b1, 1'b0});
    step(1'b0, 1'b1, 1'b0);
`endif

    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0);
    check("pre_reset", actual(), {16'h0001, 1'b1, 1'b0});
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_midrun", actual(), 18'h0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Upstream time source for the 4-digit 7-segment scanner. Produces four BCD digits in MM:SS form that feed the scanner's BCD3..BCD0 inputs directly.
- Divides the system clock into a 1 Hz count tick.
- Runs a start/pause/clear state machine and maintains a cascaded BCD seconds/minutes counter that wraps at 59:59.

Parameters:
- TICK_DIV, 100000000, system clock cycles per count tick. Minimum 2. Prescaler width is clog2(TICK_DIV).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start_stop  input  1  single-cycle pulse, already debounced and one-pulsed upstream; toggles run/pause.
- clear  input  1  single-cycle pulse; returns to 00:00 and IDLE.
- BCD3  output  4  minutes tens, 0..5.
- BCD2  output  4  minutes units, 0..9.
- BCD1  output  4  seconds tens, 0..5.
- BCD0  output  4  seconds units, 0..9.
- running  output  1  high while in state RUN.
- tick  output  1  single-cycle pulse on the cycle the time count advances.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - Prescaler 0.
  - BCD3..BCD0 = 0.
  - running = 0, tick = 0.
  - Outputs are valid immediately on assertion of rst; the block leaves reset on the first clk edge after rst deasserts.
- All outputs are registered.
- States:
  - IDLE: time 00:00, prescaler 0. start_stop -> RUN.
  - RUN: prescaler increments every cycle. start_stop -> PAUSE.
  - PAUSE: prescaler and time held. start_stop -> RUN, resuming the prescaler from its held value, not restarting it.
- clear in any state, next edge: state IDLE, prescaler 0, digits 0, tick 0.
- clear and start_stop in the same cycle: clear wins and start_stop is ignored.
- Prescaler in RUN:
  - When prescaler == TICK_DIV-1, it returns to 0 on the next edge. On that same edge, tick goes to 1 for one cycle and the time advances.
  - The first tick after IDLE->RUN arrives TICK_DIV cycles after the edge that entered RUN.
- Time advance (cascaded BCD, all digits update on the same edge):
  - BCD0 9->0 carries to BCD1; otherwise BCD0+1.
  - BCD1 5->0 with carry-in carries to BCD2.
  - BCD2 9->0 with carry-in carries to BCD3.
  - BCD3 5->0 with carry-in wraps the whole count to 00:00. No overflow flag; counting continues.
- start_stop on the same cycle the prescaler reaches TICK_DIV-1 in RUN: the tick and advance still occur on that edge, and the state moves to PAUSE on the same edge.
- Digits never hold values outside their ranges (BCD0/BCD2 0..9, BCD1/BCD3 0..5). The 7-segment decode of 10..15 (blank) is never exercised by this block.
- running = (state == RUN), registered with the state.

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_EN.
- Defined:
  - Adds input port lap (1-bit, single-cycle pulse) and an internal 16-bit display latch. BCD3..BCD0 drive from the latch.
  - Latch tracks the live count every cycle while not frozen.
  - lap pulse in RUN freezes the latch at the live value on that edge; counting continues underneath.
  - Next lap pulse unfreezes it, and the latch shows the live count from the following edge.
  - lap in IDLE or PAUSE is ignored.
  - clear or reset unfreezes and zeroes the latch.
- Not defined: no lap port, no latch; BCD outputs drive from the live count.

Test Plan (TICK_DIV=4):
- Reset then idle 20 cycles -> BCD3..0 = 0,0,0,0; running = 0; tick never asserted.
- start_stop pulse, run 40 cycles -> tick every 4 cycles; BCD0 reaches 9 then BCD1 = 1, BCD0 = 0 at the 10th tick; running = 1.
- Run to 09:59 (BCD 0,9,5,9), one more tick -> 1,0,0,0. Continue from 59:59 (5,9,5,9), one more tick -> 0,0,0,0.
- Pause when prescaler = 2, wait 10 cycles, resume -> digits frozen during the pause; the next tick arrives 2 cycles after resume.
- clear and start_stop in the same cycle while in RUN at 00:07 -> next edge state IDLE, digits 0, running = 0; no further ticks.
- With BCD_STOPWATCH_LAP_EN: lap at 00:03 -> outputs hold 0,0,0,3 while the live count reaches 00:08; second lap -> outputs show 0,0,0,8 on the following edge.
